eds_ddr_burst_writer: RTL and testbench

// - Sits downstream of the Aurora EDS/FBC parser. Consumes its 128-bit stream (tlast every BURST_LEN beats).
// - Buffers beats in a ping-pong burst RAM and emits DDR write commands {addr,len} plus matching write data.
// - Addresses advance linearly through a circular window.
// - On flush_req (EDS/FBC complete), commits any partial burst and reports flush_done once fully drained.

---
 rtl/eds_ddr_burst_writer.sv | 185 ++++++++++++++++++
 tb/tb_eds_ddr_burst_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eds_ddr_burst_writer.sv
// rtl/eds_ddr_burst_writer.sv - ping-pong buffered stream to DDR write-burst converter
module eds_ddr_burst_writer #(
    parameter int DATA_WD   = 128,
    parameter int ADDR_WD   = 32,
    parameter int BURST_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_rst,
    input  logic [ADDR_WD-1:0] cfg_base_addr,
    input  logic [ADDR_WD-1:0] cfg_win_size,
    input  logic [DATA_WD-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               m_cmd_valid,
    input  logic               m_cmd_ready,
    output logic [ADDR_WD-1:0] m_cmd_addr,
    output logic [7:0]         m_cmd_len,
    output logic [DATA_WD-1:0] m_wdata,
    output logic               m_wvalid,
    input  logic               m_wready,
    output logic               m_wlast,
    output logic [31:0]        burst_cnt,
    output logic [15:0]        wrap_cnt,
    output logic [15:0]        flush_cnt
);

    localparam int BPB    = DATA_WD / 8;
    localparam int IDX_WD = $clog2(BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t state_q, state_d;

    logic [DATA_WD-1:0] mem [2*BURST_LEN];
    logic [7:0]         len_m1 [2];
    logic [1:0]         full;
    logic               fill_half, rd_half;
    logic [IDX_WD-1:0]  fill, beat;
    logic               ready_en, flush_pend;
    logic [ADDR_WD-1:0] next_addr, cmd_addr_q, cur_addr;
    logic               at_base;
    logic [7:0]         cmd_len_q;

    logic               wr_accept, commit, done_cond, load_cmd, w_done, cmd_hs, wrap;
    logic [7:0]         commit_len;
    logic [ADDR_WD:0]   step, sum, win_end;

    assign s_axis_tready = ready_en && !full[fill_half] && !flush_pend && !cfg_rst;
    assign wr_accept     = s_axis_tvalid && s_axis_tready;

    // A flush on the same cycle as an accepted beat closes the burst including that beat.
    assign commit = (wr_accept && ((fill == IDX_WD'(BURST_LEN - 1)) || s_axis_tlast))
                 || (flush_req && (wr_accept || fill != '0));
    assign commit_len = wr_accept ? 8'(fill) : 8'(fill - IDX_WD'(1));

    assign done_cond = (flush_pend || flush_req) && (full == 2'b00) && (state_q == ST_IDLE)
                    && (fill == '0) && !wr_accept;

    // After reset or a wrap the window start is taken live from the config inputs.
    assign cur_addr = at_base ? cfg_base_addr : next_addr;
    assign step     = ((ADDR_WD+1)'(cmd_len_q) + (ADDR_WD+1)'(1)) * (ADDR_WD+1)'(BPB);
    assign sum      = {1'b0, cmd_addr_q} + step;
    assign win_end  = {1'b0, cfg_base_addr} + {1'b0, cfg_win_size};
    assign wrap     = (sum >= win_end);
    assign cmd_hs   = m_cmd_valid && m_cmd_ready;

    assign m_cmd_addr = cmd_addr_q;
    assign m_cmd_len  = cmd_len_q;
    assign m_wdata    = m_wvalid ? mem[{rd_half, beat}] : '0;

    always_comb begin
        state_d     = state_q;
        m_cmd_valid = 1'b0;
        m_wvalid    = 1'b0;
        m_wlast     = 1'b0;
        load_cmd    = 1'b0;
        w_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full[rd_half]) begin
                    load_cmd = 1'b1;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                m_wvalid = 1'b1;
                m_wlast  = (8'(beat) == cmd_len_q);
                if (m_wready && m_wlast) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[{fill_half, fill}] <= s_axis_tdata;
        if (commit) len_m1[fill_half] <= commit_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            full       <= 2'b00;
            fill_half  <= 1'b0;
            rd_half    <= 1'b0;
            fill       <= '0;
            beat       <= '0;
            ready_en   <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            next_addr  <= '0;
            at_base    <= 1'b1;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            burst_cnt  <= '0;
            wrap_cnt   <= '0;
            flush_cnt  <= '0;
        end else if (cfg_rst) begin
            state_q    <= ST_IDLE;
            full       <= 2'b00;
            fill_half  <= 1'b0;
            rd_half    <= 1'b0;
            fill       <= '0;
            beat       <= '0;
            ready_en   <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            next_addr  <= '0;
            at_base    <= 1'b1;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            burst_cnt  <= '0;
            wrap_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            ready_en   <= 1'b1;
            flush_pend <= (flush_pend || flush_req) && !done_cond;
            flush_done <= done_cond;
            if (done_cond) flush_cnt <= flush_cnt + 16'd1;

            if (wr_accept) fill <= fill + IDX_WD'(1);
            if (commit) begin
                full[fill_half] <= 1'b1;
                fill_half       <= ~fill_half;
                fill            <= '0;
            end

            if (load_cmd) begin
                cmd_addr_q <= cur_addr;
                cmd_len_q  <= len_m1[rd_half];
                beat       <= '0;
            end

            if (cmd_hs) begin
                if (wrap) begin
                    at_base  <= 1'b1;
                    wrap_cnt <= wrap_cnt + 16'd1;
                end else begin
                    at_base   <= 1'b0;
                    next_addr <= sum[ADDR_WD-1:0];
                end
            end

            if (m_wvalid && m_wready) beat <= beat + IDX_WD'(1);
            if (w_done) begin
                full[rd_half] <= 1'b0;
                rd_half       <= ~rd_half;
                beat          <= '0;
                burst_cnt     <= burst_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eds_ddr_burst_writer.sv
// tb/tb_eds_ddr_burst_writer.sv - directed self-checking bench for eds_ddr_burst_writer
module tb_eds_ddr_burst_writer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic         clk = 1'b0, rst_n = 1'b0, cfg_rst = 1'b0;
    logic [31:0]  cfg_base_addr = BASE, cfg_win_size = 32'h0001_0000;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic         flush_req = 1'b0, flush_done;
    logic         m_cmd_valid, m_cmd_ready = 1'b0;
    logic [31:0]  m_cmd_addr;
    logic [7:0]   m_cmd_len;
    logic [127:0] m_wdata;
    logic         m_wvalid, m_wready = 1'b0, m_wlast;
    logic [31:0]  burst_cnt;
    logic [15:0]  wrap_cnt, flush_cnt;

    eds_ddr_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
        .cfg_base_addr(cfg_base_addr), .cfg_win_size(cfg_win_size),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .flush_req(flush_req), .flush_done(flush_done),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .burst_cnt(burst_cnt), .wrap_cnt(wrap_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               nbeats;
        int               tper;
        bit               flush;
        logic [31:0]      win;
        int               ncmd;
        logic [3:0][31:0] addr;
        logic [3:0][7:0]  len;
        int               bursts;
        int               wraps;
        int               flushes;
    } vec_t;

    int errors = 0, checks = 0, cyc = 0;
    bit mon_en = 1'b0, rand_wr = 1'b0, rand_cr = 1'b0, wr_fixed = 1'b1, cr_fixed = 1'b1;

    logic [127:0] sent_q[$], rcv_q[$];
    bit           rlast_q[$];
    logic [31:0]  caddr_q[$];
    logic [7:0]   clen_q[$];
    int           fd_pulses = 0, fd_cyc = 0, last_w_cyc = 0;

    bit           w_stall = 1'b0, c_stall = 1'b0, p_wlast = 1'b0;
    logic [127:0] p_wdata = '0;
    logic [31:0]  p_caddr = '0;
    logic [7:0]   p_clen = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_wready    = rand_wr ? 1'($urandom_range(0, 1)) : wr_fixed;
        m_cmd_ready = rand_cr ? 1'($urandom_range(0, 1)) : cr_fixed;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (w_stall) begin
                chk("w_hold_valid", m_wvalid, 1);
                chk("w_hold_data", m_wdata, p_wdata);
                chk("w_hold_last", m_wlast, p_wlast);
            end
            if (c_stall) begin
                chk("c_hold_valid", m_cmd_valid, 1);
                chk("c_hold_addr", m_cmd_addr, p_caddr);
                chk("c_hold_len", m_cmd_len, p_clen);
            end
            if (m_cmd_valid && m_cmd_ready) begin
                caddr_q.push_back(m_cmd_addr);
                clen_q.push_back(m_cmd_len);
            end
            if (m_wvalid && m_wready) begin
                rcv_q.push_back(m_wdata);
                rlast_q.push_back(m_wlast);
                last_w_cyc = cyc;
            end
            if (flush_done) begin
                fd_pulses++;
                fd_cyc = cyc;
            end
            w_stall = m_wvalid && !m_wready;
            p_wdata = m_wdata;
            p_wlast = m_wlast;
            c_stall = m_cmd_valid && !m_cmd_ready;
            p_caddr = m_cmd_addr;
            p_clen  = m_cmd_len;
        end else begin
            w_stall = 1'b0;
            c_stall = 1'b0;
        end
    end

    task automatic clear_sb();
        sent_q.delete(); rcv_q.delete(); rlast_q.delete();
        caddr_q.delete(); clen_q.delete();
        fd_pulses = 0;
    endtask

    task automatic do_cfg_rst(input logic [31:0] win);
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_win_size = win;
        cfg_rst = 1'b1;
        @(posedge clk); #1;
        cfg_rst = 1'b0;
        clear_sb();
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic send_beats(input int n, input int tper);
        int i = 0, t = 0, last_i = -1;
        while (i < n && t < 5000) begin
            @(posedge clk); #1;
            if (i != last_i) begin
                s_axis_tdata = {32'(i), 32'(n), $urandom, $urandom};
                last_i = i;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (tper != 0) && ((i % tper) == tper - 1);
            @(negedge clk);
            t++;
            if (s_axis_tready) begin
                sent_q.push_back(s_axis_tdata);
                i++;
            end
        end
        chk("send_done", i, n);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    task automatic wait_drain(input int n, input bit want_fd);
        int t = 0;
        while ((rcv_q.size() < n || (want_fd && fd_pulses == 0)) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", (rcv_q.size() >= n) && (!want_fd || fd_pulses > 0), 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic verify(input string nm, input vec_t v);
        int k = 0, b = 0;
        bit exp_last;
        chk({nm, "_ncmd"}, caddr_q.size(), v.ncmd);
        for (int c = 0; c < v.ncmd && c < caddr_q.size(); c++) begin
            chk({nm, "_addr"}, caddr_q[c], v.addr[c]);
            chk({nm, "_len"}, clen_q[c], v.len[c]);
        end
        chk({nm, "_nbeats"}, rcv_q.size(), v.nbeats);
        for (int j = 0; j < rcv_q.size() && j < sent_q.size(); j++) begin
            chk({nm, "_data"}, rcv_q[j], sent_q[j]);
            exp_last = (k < v.ncmd) && (b == int'(v.len[k]));
            chk({nm, "_wlast"}, rlast_q[j], exp_last);
            if (exp_last) begin
                k++;
                b = 0;
            end else begin
                b++;
            end
        end
        chk({nm, "_burst_cnt"}, burst_cnt, v.bursts);
        chk({nm, "_wrap_cnt"}, wrap_cnt, v.wraps);
        chk({nm, "_flush_cnt"}, flush_cnt, v.flushes);
        chk({nm, "_fd_pulses"}, fd_pulses, v.flushes);
        if (v.flushes > 0 && v.nbeats > 0)
            chk({nm, "_fd_after_last"}, fd_cyc - last_w_cyc, 2);
    endtask

    vec_t tbl [4];
    vec_t v;

    initial begin
        // full bursts by tlast; partial burst by flush; wrap in a 2-burst window; short tlast bursts
        tbl[0] = '{nbeats: 64, tper: 32, flush: 0, win: 32'h0001_0000, ncmd: 2,
                   addr: {32'h0, 32'h0, BASE + 32'h200, BASE}, len: {8'd0, 8'd0, 8'd31, 8'd31},
                   bursts: 2, wraps: 0, flushes: 0};
        tbl[1] = '{nbeats: 40, tper: 0, flush: 1, win: 32'h0001_0000, ncmd: 2,
                   addr: {32'h0, 32'h0, BASE + 32'h200, BASE}, len: {8'd0, 8'd0, 8'd7, 8'd31},
                   bursts: 2, wraps: 0, flushes: 1};
        tbl[2] = '{nbeats: 96, tper: 32, flush: 0, win: 32'h0000_0400, ncmd: 3,
                   addr: {32'h0, BASE, BASE + 32'h200, BASE}, len: {8'd0, 8'd31, 8'd31, 8'd31},
                   bursts: 3, wraps: 1, flushes: 0};
        tbl[3] = '{nbeats: 20, tper: 5, flush: 0, win: 32'h0001_0000, ncmd: 4,
                   addr: {BASE + 32'hf0, BASE + 32'ha0, BASE + 32'h50, BASE},
                   len: {8'd4, 8'd4, 8'd4, 8'd4}, bursts: 4, wraps: 0, flushes: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_cmd_valid", m_cmd_valid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tready_0", s_axis_tready, 0);
        @(negedge clk);
        chk("rel_tready_1", s_axis_tready, 1);
        mon_en = 1'b1;

        @(posedge clk); #1;
        flush_req = 1'b1;
        @(negedge clk);
        chk("fe_done_early", flush_done, 0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        chk("fe_done", flush_done, 1);
        @(negedge clk);
        chk("fe_done_once", flush_done, 0);
        chk("fe_flush_cnt", flush_cnt, 1);

        for (int s = 0; s < 4; s++) begin
            do_cfg_rst(tbl[s].win);
            send_beats(tbl[s].nbeats, tbl[s].tper);
            if (tbl[s].flush) pulse_flush();
            wait_drain(tbl[s].nbeats, tbl[s].flush);
            verify($sformatf("vec%0d", s), tbl[s]);
        end

        do_cfg_rst(32'h0001_0000);
        cr_fixed = 1'b0;
        fork
            send_beats(96, 32);
            begin
                repeat (100) @(negedge clk);
                chk("stall_accepted", sent_q.size(), 64);
                chk("stall_tready", s_axis_tready, 0);
                cr_fixed = 1'b1;
            end
        join
        wait_drain(96, 0);
        v = '{nbeats: 96, tper: 32, flush: 0, win: 32'h0001_0000, ncmd: 3,
              addr: {32'h0, BASE + 32'h400, BASE + 32'h200, BASE}, len: {8'd0, 8'd31, 8'd31, 8'd31},
              bursts: 3, wraps: 0, flushes: 0};
        verify("stall", v);

        do_cfg_rst(32'h0001_0000);
        rand_wr = 1'b1;
        rand_cr = 1'b1;
        send_beats(64, 32);
        wait_drain(64, 0);
        rand_wr = 1'b0;
        rand_cr = 1'b0;
        v = '{nbeats: 64, tper: 32, flush: 0, win: 32'h0001_0000, ncmd: 2,
              addr: {32'h0, 32'h0, BASE + 32'h200, BASE}, len: {8'd0, 8'd0, 8'd31, 8'd31},
              bursts: 2, wraps: 0, flushes: 0};
        verify("randbp", v);

        clear_sb();
        send_beats(32, 32);
        begin
            int t = 0;
            while (rcv_q.size() < 10 && t < 500) begin
                @(negedge clk);
                t++;
            end
        end
        chk("cr_reach_beat10", rcv_q.size() >= 10, 1);
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_rst = 1'b1;
        @(posedge clk); #1;
        cfg_rst = 1'b0;
        @(negedge clk);
        chk("cr_wvalid", m_wvalid, 0);
        chk("cr_cmd_valid", m_cmd_valid, 0);
        chk("cr_burst_cnt", burst_cnt, 0);
        chk("cr_wrap_cnt", wrap_cnt, 0);
        chk("cr_tready_0", s_axis_tready, 0);
        @(negedge clk);
        chk("cr_tready_1", s_axis_tready, 1);
        clear_sb();
        mon_en = 1'b1;
        send_beats(32, 0);
        wait_drain(32, 0);
        v = '{nbeats: 32, tper: 0, flush: 0, win: 32'h0001_0000, ncmd: 1,
              addr: {32'h0, 32'h0, 32'h0, BASE}, len: {8'd0, 8'd0, 8'd0, 8'd31},
              bursts: 1, wraps: 0, flushes: 0};
        verify("after_cfg_rst", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
